// File: rtl/pong_pkg.sv
// Shared types and default constants for the pong match controller.
package pong_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SERVE  = 3'd1,
        PLAY   = 3'd2,
        PAUSED = 3'd3,
        POINT  = 3'd4,
        OVER   = 3'd5
    } match_state_t;

    localparam int DEF_SCORE_WIDTH = 4;
    localparam int DEF_WIN_SCORE   = 7;
    localparam int DEF_HOLD_TICKS  = 60;
    localparam int DEF_SERVE_TICKS = 30;
    localparam int DEF_TIMER_WIDTH = 8;

    // Winner flags packed as [1]=player 1, [0]=player 0.
    function automatic logic [1:0] win_onehot(input logic p0_won, input logic p1_won);
        return {p1_won, p0_won};
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Frame-tick counter shared by the SERVE and POINT hold phases.
// done pulses on the tick that completes 'target' ticks since the last clear.
module tick_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             tick,
    input  logic [WIDTH-1:0] target,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // Next count: clear wins over tick so a state change always starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = cnt_q + ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Independent of clr so the FSM can use done to compute clr without a loop.
    assign done = tick && (cnt_q == (target - ONE));

endmodule

// File: rtl/pong_score_ctrl.sv
// Match controller: scores, serve/play/point-hold/game-over sequencing,
// and ball-stage control (re-centre and freeze). All outputs are Moore.
module pong_score_ctrl
    import pong_pkg::*;
#(
    parameter int SCORE_WIDTH = DEF_SCORE_WIDTH,
    parameter int WIN_SCORE   = DEF_WIN_SCORE,
    parameter int HOLD_TICKS  = DEF_HOLD_TICKS,
    parameter int SERVE_TICKS = DEF_SERVE_TICKS,
    parameter int TIMER_WIDTH = DEF_TIMER_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_tick,
    input  logic                   start,
    input  logic                   pause_btn,
    input  logic [1:0]             win,
    output logic                   ball_rst,
    output logic                   ball_pause,
    output logic [SCORE_WIDTH-1:0] score0,
    output logic [SCORE_WIDTH-1:0] score1,
    output logic                   game_over,
    output logic [1:0]             winner
);

    localparam logic [SCORE_WIDTH-1:0] WIN_S   = SCORE_WIDTH'(WIN_SCORE);
    localparam logic [SCORE_WIDTH-1:0] S_ONE   = SCORE_WIDTH'(1);
    localparam logic [TIMER_WIDTH-1:0] HOLD_T  = TIMER_WIDTH'(HOLD_TICKS);
    localparam logic [TIMER_WIDTH-1:0] SERVE_T = TIMER_WIDTH'(SERVE_TICKS);

    match_state_t           state_q, state_d;
    logic [SCORE_WIDTH-1:0] score0_q, score0_d;
    logic [SCORE_WIDTH-1:0] score1_q, score1_d;

    logic                   tmr_clr;
    logic                   tmr_done;
    logic [TIMER_WIDTH-1:0] tmr_target;
    logic                   timed_state;
    logic                   p0_at_win;
    logic                   p1_at_win;

    assign p0_at_win   = (score0_q == WIN_S);
    assign p1_at_win   = (score1_q == WIN_S);
    assign timed_state = (state_q == SERVE) || (state_q == POINT);
    assign tmr_target  = (state_q == POINT) ? HOLD_T : SERVE_T;
    // Timer only runs in the two timed phases and restarts on any transition.
    assign tmr_clr     = (state_d != state_q) || !timed_state;

    tick_timer #(
        .WIDTH (TIMER_WIDTH)
    ) u_tick_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .tick   (frame_tick),
        .target (tmr_target),
        .done   (tmr_done)
    );

    // Next-state and score update; scores only move on the PLAY->POINT edge.
    always_comb begin
        state_d  = state_q;
        score0_d = score0_q;
        score1_d = score1_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = SERVE;
                    score0_d = '0;
                    score1_d = '0;
                end
            end
            SERVE: begin
                if (tmr_done) state_d = PLAY;
            end
            PLAY: begin
                // A point outranks a pause press in the same cycle.
                if (win != 2'b00) begin
                    state_d = POINT;
                    if (win == 2'b01 && !p0_at_win) score0_d = score0_q + S_ONE;
                    if (win == 2'b10 && !p1_at_win) score1_d = score1_q + S_ONE;
                end else if (pause_btn) begin
                    state_d = PAUSED;
                end
            end
            PAUSED: begin
                if (pause_btn) state_d = PLAY;
            end
            POINT: begin
                if (tmr_done) state_d = (p0_at_win || p1_at_win) ? OVER : SERVE;
            end
            OVER: begin
                if (start) begin
                    state_d  = SERVE;
                    score0_d = '0;
                    score1_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and score registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            score0_q <= '0;
            score1_q <= '0;
        end else begin
            state_q  <= state_d;
            score0_q <= score0_d;
            score1_q <= score1_d;
        end
    end

    // Output decode purely from registered state and scores.
    always_comb begin
        ball_rst   = (state_q == IDLE) || (state_q == SERVE) || (state_q == OVER);
        ball_pause = (state_q == PAUSED) || (state_q == POINT);
        game_over  = (state_q == OVER);
        winner     = (state_q == OVER) ? win_onehot(p0_at_win, p1_at_win) : 2'b00;
    end

    assign score0 = score0_q;
    assign score1 = score1_q;

endmodule

// File: tb/tb_pong_score_ctrl.sv
// Randomized and directed bench for pong_score_ctrl against a tick-countdown model.
module tb_pong_score_ctrl;

    localparam int SW  = 4;
    localparam int WS  = 3;
    localparam int HT  = 60;
    localparam int ST  = 30;
    localparam int TW  = 8;

    localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_PAUSED = 3, M_POINT = 4, M_OVER = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_tick = 1'b0;
    logic          start = 1'b0;
    logic          pause_btn = 1'b0;
    logic [1:0]    win = 2'b00;
    logic          ball_rst, ball_pause, game_over;
    logic [SW-1:0] score0, score1;
    logic [1:0]    winner;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: phase, scores, ticks remaining in the current timed phase.
    int m_mode = M_IDLE;
    int m_s0 = 0, m_s1 = 0, m_left = 0;

    always #5 clk = ~clk;

    pong_score_ctrl #(
        .SCORE_WIDTH (SW),
        .WIN_SCORE   (WS),
        .HOLD_TICKS  (HT),
        .SERVE_TICKS (ST),
        .TIMER_WIDTH (TW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .start      (start),
        .pause_btn  (pause_btn),
        .win        (win),
        .ball_rst   (ball_rst),
        .ball_pause (ball_pause),
        .score0     (score0),
        .score1     (score1),
        .game_over  (game_over),
        .winner     (winner)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_s0 = 0; m_s1 = 0; m_left = 0;
    endtask

    task automatic new_match();
        m_mode = M_SERVE; m_s0 = 0; m_s1 = 0; m_left = ST;
    endtask

    // One clock of the match rules, using the inputs present at the edge.
    task automatic model_clock();
        case (m_mode)
            M_IDLE, M_OVER: if (start) new_match();
            M_SERVE: if (frame_tick) begin
                m_left--;
                if (m_left == 0) m_mode = M_PLAY;
            end
            M_PLAY: begin
                if (win != 2'b00) begin
                    m_mode = M_POINT;
                    m_left = HT;
                    if (win == 2'b01 && m_s0 < WS) m_s0++;
                    if (win == 2'b10 && m_s1 < WS) m_s1++;
                end else if (pause_btn) begin
                    m_mode = M_PAUSED;
                end
            end
            M_PAUSED: if (pause_btn) m_mode = M_PLAY;
            M_POINT: if (frame_tick) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_s0 == WS || m_s1 == WS) m_mode = M_OVER;
                    else begin m_mode = M_SERVE; m_left = ST; end
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_all();
        logic [1:0] exp_w;
        exp_w = (m_mode == M_OVER) ? {1'(m_s1 == WS), 1'(m_s0 == WS)} : 2'b00;
        chk("ball_rst", ball_rst, (m_mode == M_IDLE || m_mode == M_SERVE || m_mode == M_OVER) ? 1 : 0);
        chk("ball_pause", ball_pause, (m_mode == M_PAUSED || m_mode == M_POINT) ? 1 : 0);
        chk("score0", score0, m_s0);
        chk("score1", score1, m_s1);
        chk("game_over", game_over, (m_mode == M_OVER) ? 1 : 0);
        chk("winner", winner, exp_w);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ball_rst"}, ball_rst, 1);
        chk({tag, "_ball_pause"}, ball_pause, 0);
        chk({tag, "_score0"}, score0, 0);
        chk({tag, "_score1"}, score1, 0);
        chk({tag, "_game_over"}, game_over, 0);
        chk({tag, "_winner"}, winner, 0);
    endtask

    // Advance one clock: model follows the edge, outputs sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        check_all();
    endtask

    task automatic pulse_step(input logic s, input logic p, input logic [1:0] w);
        start = s; pause_btn = p; win = w;
        step();
        start = 1'b0; pause_btn = 1'b0; win = 2'b00;
    endtask

    // Let time pass with random ticks until the model reaches a phase.
    task automatic run_until(input int target, input int max_cyc);
        int n = 0;
        while (m_mode != target && n < max_cyc) begin
            frame_tick = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        frame_tick = 1'b0;
        chk("phase_timeout", (m_mode == target) ? 1 : 0, 1);
    endtask

    initial begin
        int hold;
        // Reset and idle.
        #12;
        check_reset_vals("in_reset");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 100; i++) step();

        // Serve countdown, then a point held high for 5 cycles.
        pulse_step(1'b1, 1'b0, 2'b00);
        run_until(M_PLAY, 1000);
        win = 2'b01;
        for (int i = 0; i < 5; i++) step();
        win = 2'b00;
        chk("score0_once", score0, 1);
        run_until(M_SERVE, 1000);
        run_until(M_PLAY, 1000);

        // Pause, ignored win while paused, resume, win beats pause.
        pulse_step(1'b0, 1'b1, 2'b00);
        win = 2'b01;
        for (int i = 0; i < 3; i++) step();
        win = 2'b00;
        pulse_step(1'b0, 1'b1, 2'b00);
        for (int i = 0; i < 4; i++) step();
        pulse_step(1'b0, 1'b1, 2'b01);
        chk("win_over_pause", ball_pause, 1);
        run_until(M_PLAY, 1000);

        // Draw re-serve.
        pulse_step(1'b0, 1'b0, 2'b11);
        run_until(M_PLAY, 1000);

        // Player 1 takes three points and the match.
        for (int k = 0; k < WS && m_mode != M_OVER; k++) begin
            run_until(M_PLAY, 1000);
            pulse_step(1'b0, 1'b0, 2'b10);
        end
        run_until(M_OVER, 1000);
        chk("final_winner", winner, 2'b10);
        chk("final_score1", score1, WS);
        for (int i = 0; i < 5; i++) step();
        pulse_step(1'b1, 1'b0, 2'b00);

        // Async reset in POINT with score0 at 2.
        for (int k = 0; k < 2; k++) begin
            run_until(M_PLAY, 1000);
            pulse_step(1'b0, 1'b0, 2'b01);
        end
        run_until(M_PLAY, 1000);
        pulse_step(1'b0, 1'b0, 2'b10);
        for (int i = 0; i < 3; i++) step();
        chk("pre_rst_score0", score0, 2);
        #2 rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();

        // Random play.
        hold = 0;
        for (int c = 0; c < 6000; c++) begin
            frame_tick = 1'($urandom_range(0, 1));
            start      = ($urandom_range(0, 299) == 0);
            pause_btn  = ($urandom_range(0, 39) == 0);
            if (hold > 0) hold--;
            else if ($urandom_range(0, 24) == 0) begin
                win  = 2'($urandom_range(1, 3));
                hold = $urandom_range(0, 4);
            end else win = 2'b00;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
